// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//
// Purpose:
//   Shared definitions for the 5-stage MIPS pipeline control blocks.
//   - Register index width.
//   - Forwarding mux select encodings used by the execute-stage ALU inputs.
//   - Hazard controller sequencing states.
//   - A register compare helper that never matches register 0.
//
// Ports:
//   None. This is a package.
// ---------------------------------------------------------------------------
package mips_pkg;

  // Width of a register file index (32 architectural registers).
  localparam int REG_W = 5;

  // ALU source select encodings.
  // NONE takes the register file value latched in D/E.
  // WB takes the result being written back.
  // MEM takes the ALU result sitting in E/M.
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  // Sequencing states of the hazard controller.
  // RUN      : normal issue, only RAW/branch hazards apply.
  // MEM_WAIT : a data-memory access in M is outstanding.
  // HALT     : the memory wait watchdog expired. Only reset leaves this state.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } hz_state_t;

  // Register 0 is hard-wired to zero.
  // A write to it is discarded, so it must never produce a hazard or a forward.
  function automatic logic regMatch(input logic [REG_W-1:0] a,
                                    input logic [REG_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// ---------------------------------------------------------------------------
// pipe_fwd_unit
//
// Purpose:
//   Purely combinational forwarding comparators for the MIPS pipeline.
//   - The execute-stage ALU operands may take a newer value from E/M or M/W.
//   - The decode-stage branch comparator may take a newer value from E/M.
//
// Ports:
//   rsD_i, rtD_i         : decode-stage source registers
//   rsE_i, rtE_i         : execute-stage source registers
//   writeRegM_i          : destination register of the instruction in M
//   regWriteM_i          : the instruction in M writes the register file
//   writeRegW_i          : destination register of the instruction in W
//   regWriteW_i          : the instruction in W writes the register file
//   forwardAE_o          : ALU source A select (FWD_NONE / FWD_WB / FWD_MEM)
//   forwardBE_o          : ALU source B select
//   forwardAD_o          : branch comparator A takes the M-stage result
//   forwardBD_o          : branch comparator B takes the M-stage result
// ---------------------------------------------------------------------------
module pipe_fwd_unit
  import mips_pkg::*;
(
  input  logic [REG_W-1:0] rsD_i,
  input  logic [REG_W-1:0] rtD_i,
  input  logic [REG_W-1:0] rsE_i,
  input  logic [REG_W-1:0] rtE_i,
  input  logic [REG_W-1:0] writeRegM_i,
  input  logic             regWriteM_i,
  input  logic [REG_W-1:0] writeRegW_i,
  input  logic             regWriteW_i,
  output logic [1:0]       forwardAE_o,
  output logic [1:0]       forwardBE_o,
  output logic             forwardAD_o,
  output logic             forwardBD_o
);

  // Select the freshest producer of an execute-stage operand.
  // The M-stage instruction is younger than the W-stage one.
  // When both write the same register, the M-stage value is the architecturally correct one.
  function automatic logic [1:0] selectFwd(input logic [REG_W-1:0] src);
    logic [1:0] sel;
    sel = FWD_NONE;
    if (regWriteM_i && regMatch(writeRegM_i, src)) begin
      sel = FWD_MEM;
    end else if (regWriteW_i && regMatch(writeRegW_i, src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  // Execute-stage ALU operand selects.
  always_comb begin
    forwardAE_o = selectFwd(rsE_i);
    forwardBE_o = selectFwd(rtE_i);
  end

  // Decode-stage branch comparator bypass.
  // Only the M-stage result is bypassed.
  // A W-stage value reaches decode through the register file's write-first behaviour.
  always_comb begin
    forwardAD_o = regWriteM_i && regMatch(writeRegM_i, rsD_i);
    forwardBD_o = regWriteM_i && regMatch(writeRegM_i, rtD_i);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Purpose:
//   Hazard and sequencing controller for the 5-stage MIPS pipeline.
//   - Drives stall/flush controls for the F/D, D/E, E/M and M/W latches.
//   - Drives operand forwarding selects.
//   - Resolves load-use and decode-stage branch hazards.
//   - Holds the whole pipeline while a data-memory access in M is outstanding.
//   - A watchdog halts the pipe if memory never answers.
//   - Two wrapping performance counters track stall and flush cycles.
//
// Parameters:
//   MEM_TIMEOUT : consecutive MEM_WAIT cycles tolerated before HALT
//   CNT_W       : width of the performance counters
//
// Ports:
//   clk, rst                : clock (rising edge), synchronous active-high reset
//   RsD, RtD, BranchD,
//   PCSrcD                  : decode-stage sources, branch flag, branch taken
//   RsE, RtE, WriteRegE,
//   RegWriteE, MemtoRegE    : execute-stage sources, destination, controls
//   WriteRegM, RegWriteM,
//   MemtoRegM               : memory-stage destination and controls
//   mem_req_M, mem_ready_M  : data-memory access request / completion in M
//   WriteRegW, RegWriteW    : writeback-stage destination and write enable
//   StallF/D/E/M            : hold PC, F/D, D/E, E/M
//   FlushD/E/W              : clear F/D, D/E, M/W (insert bubble)
//   ForwardAE/BE            : ALU operand selects
//   ForwardAD/BD            : branch comparator bypass from M
//   halted                  : sticky watchdog error (registered)
//   stall_cnt, flush_cnt    : performance counters
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] RsD,
  input  logic [REG_W-1:0] RtD,
  input  logic             BranchD,
  input  logic             PCSrcD,
  input  logic [REG_W-1:0] RsE,
  input  logic [REG_W-1:0] RtE,
  input  logic [REG_W-1:0] WriteRegE,
  input  logic             RegWriteE,
  input  logic             MemtoRegE,
  input  logic [REG_W-1:0] WriteRegM,
  input  logic             RegWriteM,
  input  logic             MemtoRegM,
  input  logic             mem_req_M,
  input  logic             mem_ready_M,
  input  logic [REG_W-1:0] WriteRegW,
  input  logic             RegWriteW,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // The wait counter only ever holds 0 .. MEM_TIMEOUT-1.
  // On the last of those values the FSM either returns to RUN or halts.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  hz_state_t         state_q, state_d;
  logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0]  flushCnt_q, flushCnt_d;

  logic lwStall;
  logic brStall;
  logic memStall;

  // Forwarding comparators live in their own purely combinational block.
  pipe_fwd_unit uFwd (
    .rsD_i       (RsD),
    .rtD_i       (RtD),
    .rsE_i       (RsE),
    .rtE_i       (RtE),
    .writeRegM_i (WriteRegM),
    .regWriteM_i (RegWriteM),
    .writeRegW_i (WriteRegW),
    .regWriteW_i (RegWriteW),
    .forwardAE_o (ForwardAE),
    .forwardBE_o (ForwardBE),
    .forwardAD_o (ForwardAD),
    .forwardBD_o (ForwardBD)
  );

  // Hazard detection.
  // Load-use: a load in E produces its value too late for the next instruction's execute.
  // That instruction waits one cycle in decode.
  // Branch: the comparator runs in decode.
  // An ALU result still in E, or a load result still in M, cannot be bypassed in time.
  // Memory: the instruction in M is waiting on the data memory.
  // In RUN this is the first cycle of the wait. In MEM_WAIT it continues until ready.
  always_comb begin
    lwStall  = MemtoRegE && (regMatch(RtE, RsD) || regMatch(RtE, RtD));
    brStall  = BranchD &&
               ((RegWriteE && (regMatch(WriteRegE, RsD) || regMatch(WriteRegE, RtD))) ||
                (MemtoRegM && (regMatch(WriteRegM, RsD) || regMatch(WriteRegM, RtD))));
    memStall = ((state_q == RUN) && mem_req_M && !mem_ready_M) ||
               ((state_q == MEM_WAIT) && !mem_ready_M);
  end

  // Sequencing FSM next state and watchdog counter.
  // The counter is cleared on entry to MEM_WAIT and counts each cycle spent there.
  // A ready in the final tolerated cycle still wins and returns to RUN.
  // A ready seen in RUN without an outstanding request is ignored.
  // Reset overrides everything and lands back in RUN with a clean counter.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    unique case (state_q)
      RUN: begin
        if (mem_req_M && !mem_ready_M) begin
          state_d   = MEM_WAIT;
          waitCnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (mem_ready_M) begin
          state_d = RUN;
        end else if (waitCnt_q == WAIT_LAST) begin
          state_d = HALT;
        end else begin
          waitCnt_d = waitCnt_q + 1'b1;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d   = RUN;
        waitCnt_d = '0;
      end
    endcase
    if (rst) begin
      state_d   = RUN;
      waitCnt_d = '0;
    end
    halted_d = (state_d == HALT);
  end

  // Stall and flush priority.
  // Reset bubbles every latch.
  // A halted pipe freezes everything, and the M/W flush keeps garbage out of the register file.
  // A memory wait freezes F through M, and the M/W flush stops the stuck access from retiring twice.
  // Load-use and branch hazards hold F and D and push a bubble into E.
  // The D flush for a taken branch only applies when nothing upstream is held.
  // Otherwise the held branch would be squashed before it resolves.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else if (state_q == HALT) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (memStall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (lwStall || brStall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end else begin
      FlushD = PCSrcD;
    end
  end

  // Performance counters wrap naturally at 2^CNT_W.
  // They are frozen while reset is held. The register block clears them on reset.
  always_comb begin
    stallCnt_d = stallCnt_q + {{(CNT_W-1){1'b0}}, StallF};
    flushCnt_d = flushCnt_q + {{(CNT_W-1){1'b0}}, (FlushD | FlushE)};
  end

  // State, watchdog and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      waitCnt_q  <= '0;
      halted_q   <= 1'b0;
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      halted_q   <= halted_d;
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  assign halted    = halted_q;
  assign stall_cnt = stallCnt_q;
  assign flush_cnt = flushCnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Purpose:
//   Directed testbench for pipe_hazard_ctrl, built with MEM_TIMEOUT = 4.
//   - A behavioural model of the hazard rules is checked against the DUT on every cycle.
//   - Hand-computed literal expectations pin the key scenarios.
//
// Ports:
//   None. This is the top level of the simulation.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
  import mips_pkg::*;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 32;

  logic       clk;
  logic       rst;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       BranchD, PCSrcD, RegWriteE, MemtoRegE, RegWriteM, MemtoRegM;
  logic       mem_req_M, mem_ready_M, RegWriteW;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic       ForwardAD, ForwardBD, halted;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int total;
  int bad;

  typedef struct packed {
    logic       rst;
    logic [4:0] RsD;
    logic [4:0] RtD;
    logic       BranchD;
    logic       PCSrcD;
    logic [4:0] RsE;
    logic [4:0] RtE;
    logic [4:0] WriteRegE;
    logic       RegWriteE;
    logic       MemtoRegE;
    logic [4:0] WriteRegM;
    logic       RegWriteM;
    logic       MemtoRegM;
    logic       memReq;
    logic       memReady;
    logic [4:0] WriteRegW;
    logic       RegWriteW;
  } stim_t;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .RsD(RsD), .RtD(RtD), .BranchD(BranchD), .PCSrcD(PCSrcD),
    .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
    .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .mem_req_M(mem_req_M), .mem_ready_M(mem_ready_M),
    .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish in time, got running, expected finished");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic driveInputs(input stim_t s);
    rst         = s.rst;
    RsD         = s.RsD;
    RtD         = s.RtD;
    BranchD     = s.BranchD;
    PCSrcD      = s.PCSrcD;
    RsE         = s.RsE;
    RtE         = s.RtE;
    WriteRegE   = s.WriteRegE;
    RegWriteE   = s.RegWriteE;
    MemtoRegE   = s.MemtoRegE;
    WriteRegM   = s.WriteRegM;
    RegWriteM   = s.RegWriteM;
    MemtoRegM   = s.MemtoRegM;
    mem_req_M   = s.memReq;
    mem_ready_M = s.memReady;
    WriteRegW   = s.WriteRegW;
    RegWriteW   = s.RegWriteW;
  endtask

  // Inputs change 1 unit after the rising edge.
  // Literal checks are then made 3 units later, well before the next edge.
  task automatic applyStimulus(input stim_t s);
    @(posedge clk);
    #1;
    driveInputs(s);
    #3;
  endtask

  function automatic bit nzEq(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  // Behavioural model, checked every cycle on the falling edge.
  // The memory wait is tracked as "waiting or not" plus the number of fully unanswered wait cycles.
  // The pipe halts once that number reaches MEM_TIMEOUT.
  initial begin : compareProc
    bit          mWaiting, mHalted;
    int          mWaitCycles;
    logic [31:0] mStall, mFlush;
    logic [1:0]  eAE, eBE;
    logic        eAD, eBD, lw, br, mem;
    logic        eSF, eSD, eSE, eSM, eFD, eFE, eFW;
    mWaiting = 0; mHalted = 0; mWaitCycles = 0; mStall = '0; mFlush = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      eAE = (RegWriteM && nzEq(WriteRegM, RsE)) ? 2'b10 :
            (RegWriteW && nzEq(WriteRegW, RsE)) ? 2'b01 : 2'b00;
      eBE = (RegWriteM && nzEq(WriteRegM, RtE)) ? 2'b10 :
            (RegWriteW && nzEq(WriteRegW, RtE)) ? 2'b01 : 2'b00;
      eAD = RegWriteM && nzEq(WriteRegM, RsD);
      eBD = RegWriteM && nzEq(WriteRegM, RtD);
      lw  = MemtoRegE && (nzEq(RtE, RsD) || nzEq(RtE, RtD));
      br  = BranchD && ((RegWriteE && (nzEq(WriteRegE, RsD) || nzEq(WriteRegE, RtD))) ||
                        (MemtoRegM && (nzEq(WriteRegM, RsD) || nzEq(WriteRegM, RtD))));
      mem = !mHalted && (mWaiting ? !mem_ready_M : (mem_req_M && !mem_ready_M));
      {eSF, eSD, eSE, eSM, eFD, eFE, eFW} = '0;
      if (rst) begin
        eFD = 1; eFE = 1; eFW = 1;
      end else if (mHalted || mem) begin
        eSF = 1; eSD = 1; eSE = 1; eSM = 1; eFW = 1;
      end else if (lw || br) begin
        eSF = 1; eSD = 1; eFE = 1;
      end else begin
        eFD = PCSrcD;
      end
      checkOutput("model.ForwardAE", ForwardAE, eAE);
      checkOutput("model.ForwardBE", ForwardBE, eBE);
      checkOutput("model.ForwardAD", ForwardAD, eAD);
      checkOutput("model.ForwardBD", ForwardBD, eBD);
      checkOutput("model.stalls", {StallF, StallD, StallE, StallM}, {eSF, eSD, eSE, eSM});
      checkOutput("model.flushes", {FlushD, FlushE, FlushW}, {eFD, eFE, eFW});
      checkOutput("model.halted", halted, mHalted);
      checkOutput("model.stall_cnt", stall_cnt, mStall);
      checkOutput("model.flush_cnt", flush_cnt, mFlush);
      if (rst) begin
        mWaiting = 0; mHalted = 0; mWaitCycles = 0; mStall = '0; mFlush = '0;
      end else begin
        if (eSF) mStall = mStall + 1;
        if (eFD || eFE) mFlush = mFlush + 1;
        if (!mHalted) begin
          if (mWaiting) begin
            if (mem_ready_M) begin
              mWaiting = 0;
            end else begin
              mWaitCycles++;
              if (mWaitCycles == MEM_TIMEOUT) begin
                mHalted  = 1;
                mWaiting = 0;
              end
            end
          end else if (mem_req_M && !mem_ready_M) begin
            mWaiting    = 1;
            mWaitCycles = 0;
          end
        end
      end
    end
  end

  // Directed scenarios with hand-computed literal expectations.
  initial begin : mainProc
    stim_t s;
    total = 0;
    bad   = 0;
    s = '0;
    s.rst = 1;
    driveInputs(s);

    // Reset held: all flushes, no stalls.
    applyStimulus(s);
    checkOutput("rst.flushes", {FlushD, FlushE, FlushW}, 3'b111);
    checkOutput("rst.stalls", {StallF, StallD, StallE, StallM}, 4'b0000);

    s.rst = 0;
    applyStimulus(s);
    checkOutput("idle.counters", {stall_cnt, flush_cnt}, 64'd0);
    checkOutput("idle.halted", halted, 1'b0);

    // Forwarding: M over W, then W alone, then register 0 never forwards.
    s.RsE = 8; s.RtE = 8; s.WriteRegM = 8; s.RegWriteM = 1; s.WriteRegW = 8; s.RegWriteW = 1; s.RsD = 8;
    applyStimulus(s);
    checkOutput("fwd.mem", {ForwardAE, ForwardBE}, 4'b1010);
    checkOutput("fwd.AD", ForwardAD, 1'b1);
    s.RegWriteM = 0;
    applyStimulus(s);
    checkOutput("fwd.wb", {ForwardAE, ForwardBE}, 4'b0101);
    s.RsE = 0;
    applyStimulus(s);
    checkOutput("fwd.r0", {ForwardAE, ForwardBE}, 4'b0001);
    s.WriteRegW = 0; s.RsE = 0; s.RtE = 0;
    s.MemtoRegE = 1; s.RsD = 0;
    applyStimulus(s);
    checkOutput("lw.r0", StallF, 1'b0);

    // Load-use for exactly one cycle.
    s = '0;
    s.MemtoRegE = 1; s.RtE = 9; s.RsD = 9;
    applyStimulus(s);
    checkOutput("lw.ctrl", {StallF, StallD, FlushE, FlushD}, 4'b1110);
    s = '0;
    applyStimulus(s);
    checkOutput("lw.after", StallF, 1'b0);
    checkOutput("lw.cnt", {stall_cnt, flush_cnt}, {32'd1, 32'd1});

    // Branch hazards against E, then against a load in M, then a taken branch.
    s.BranchD = 1; s.RtD = 4; s.RegWriteE = 1; s.WriteRegE = 4;
    applyStimulus(s);
    checkOutput("br.E", {StallF, StallD, FlushE}, 3'b111);
    s.RegWriteE = 0; s.MemtoRegM = 1; s.WriteRegM = 4;
    applyStimulus(s);
    checkOutput("br.M", {StallF, StallD, FlushE}, 3'b111);
    s.MemtoRegM = 0; s.WriteRegM = 0; s.PCSrcD = 1;
    applyStimulus(s);
    checkOutput("br.taken", {StallF, FlushD}, 2'b01);
    s = '0;
    applyStimulus(s);
    checkOutput("br.cnt", {stall_cnt, flush_cnt}, {32'd3, 32'd4});

    // Memory wait of 3 cycles; a load-use hazard during it must not flush E.
    s.memReq = 1;
    applyStimulus(s);
    checkOutput("mem.c1", {StallF, StallD, StallE, StallM, FlushW}, 5'b11111);
    s.MemtoRegE = 1; s.RtE = 9; s.RsD = 9;
    applyStimulus(s);
    checkOutput("mem.lw", {StallM, FlushE, FlushD}, 3'b100);
    s.MemtoRegE = 0; s.RtE = 0; s.RsD = 0;
    applyStimulus(s);
    checkOutput("mem.c3", {StallF, StallM, FlushW}, 3'b111);
    s.memReady = 1;
    applyStimulus(s);
    checkOutput("mem.ready", {StallF, StallM, FlushW}, 3'b000);
    s = '0;
    applyStimulus(s);
    checkOutput("mem.cnt", {stall_cnt, flush_cnt}, {32'd6, 32'd4});

    // Watchdog: one RUN cycle, then 4 unanswered MEM_WAIT cycles halt the pipe.
    s.memReq = 1;
    for (int i = 0; i < 5; i++) applyStimulus(s);
    checkOutput("wd.pre", halted, 1'b0);
    s = '0; s.memReady = 1;
    applyStimulus(s);
    checkOutput("wd.halted", halted, 1'b1);
    checkOutput("wd.stalls", {StallF, StallD, StallE, StallM, FlushW, FlushD}, 6'b111110);
    applyStimulus(s);
    checkOutput("wd.sticky", {halted, stall_cnt}, {1'b1, 32'd12});

    // Reset out of HALT.
    s = '0; s.rst = 1;
    applyStimulus(s);
    checkOutput("wd.rst", {StallF, StallM, FlushD, FlushE, FlushW}, 5'b00111);
    s.rst = 0;
    applyStimulus(s);
    checkOutput("wd.cleared", {halted, StallF, stall_cnt, flush_cnt}, {2'b00, 64'd0});

    // Ready arriving in the timeout cycle returns to RUN.
    s.memReq = 1;
    for (int i = 0; i < 4; i++) applyStimulus(s);
    s.memReady = 1;
    applyStimulus(s);
    checkOutput("to.ready", StallF, 1'b0);
    s = '0;
    applyStimulus(s);
    checkOutput("to.run", {halted, StallF, stall_cnt}, {2'b00, 32'd4});

    // Reset in the middle of a memory wait, then a stray ready is ignored.
    s.memReq = 1;
    applyStimulus(s);
    applyStimulus(s);
    s.rst = 1;
    applyStimulus(s);
    checkOutput("mw.rst", {StallF, FlushE, FlushW}, 3'b011);
    s = '0;
    applyStimulus(s);
    checkOutput("mw.after", {StallF, halted, stall_cnt}, {2'b00, 32'd0});
    s.memReady = 1;
    applyStimulus(s);
    checkOutput("mw.stray", {StallF, StallM}, 2'b00);
    s = '0;
    applyStimulus(s);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage MIPS pipeline.
- Drives stall, flush and forwarding selects for the F/D, D/E, E/M and M/W pipeline latches.
- Resolves RAW hazards, load-use hazards, decode-stage branch hazards and multi-cycle data-memory waits.
- Keeps a memory-wait watchdog and performance counters.

Parameters:
MEM_TIMEOUT, 255, max consecutive MEM_WAIT cycles before HALT
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
RsD  in  5  decode source reg A
RtD  in  5  decode source reg B
BranchD  in  1  branch in decode
PCSrcD  in  1  branch taken (resolved in decode)
RsE  in  5  execute source reg A
RtE  in  5  execute source reg B
WriteRegE  in  5  execute destination
RegWriteE  in  1  execute writes regfile
MemtoRegE  in  1  execute is load
WriteRegM  in  5  memory destination
RegWriteM  in  1  memory writes regfile
MemtoRegM  in  1  memory is load
mem_req_M  in  1  data-memory access in M
mem_ready_M  in  1  data-memory completes this cycle
WriteRegW  in  5  writeback destination
RegWriteW  in  1  writeback writes regfile
StallF  out  1  hold PC
StallD  out  1  hold F/D latch
StallE  out  1  hold D/E latch
StallM  out  1  hold E/M latch
FlushD  out  1  clear F/D latch
FlushE  out  1  clear D/E latch (bubble)
FlushW  out  1  clear M/W latch (bubble)
ForwardAE  out  2  ALU src A select
ForwardBE  out  2  ALU src B select
ForwardAD  out  1  branch comparator A from M
ForwardBD  out  1  branch comparator B from M
halted  out  1  sticky watchdog error
stall_cnt  out  CNT_W  cycles with StallF=1
flush_cnt  out  CNT_W  cycles with FlushD or FlushE=1

Behaviour:
- Clocking: single clock clk. Reset rst is synchronous and active-high.
- Register 0 never matches in any hazard or forward compare.
- ForwardAE: FWD_MEM (10) if RegWriteM and WriteRegM==RsE; else FWD_WB (01) if RegWriteW and WriteRegW==RsE; else FWD_NONE (00). M has priority over W.
- ForwardBE: same rule using RtE.
- ForwardAD = RegWriteM and WriteRegM==RsD. ForwardBD likewise with RtD.
- lwstall = MemtoRegE and (RtE==RsD or RtE==RtD).
- brstall = BranchD and ((RegWriteE and WriteRegE in {RsD,RtD}) or (MemtoRegM and WriteRegM in {RsD,RtD})).
- memstall = (state==RUN and mem_req_M and !mem_ready_M) or (state==MEM_WAIT and !mem_ready_M).
- All stall, flush and forward outputs are combinational, same cycle as the inputs.
- Priority, highest first:
  - rst: FlushD=FlushE=FlushW=1, all stalls 0.
  - HALT: all four stalls 1, FlushW=1.
  - memstall: StallF/D/E/M=1, FlushW=1, FlushD=FlushE=0.
  - lwstall or brstall: StallF=StallD=1, FlushE=1, FlushD=0.
  - otherwise: FlushD=PCSrcD.
- FSM states:
  - RUN -> MEM_WAIT when mem_req_M and !mem_ready_M.
  - MEM_WAIT -> RUN when mem_ready_M.
  - MEM_WAIT -> HALT when wait_cnt==MEM_TIMEOUT-1 and !mem_ready_M.
  - HALT -> HALT until rst.
- wait_cnt: cleared on entering MEM_WAIT; increments each MEM_WAIT cycle. If mem_ready_M arrives in the same cycle as the timeout, the transition is to RUN.
- halted = (state==HALT), registered.
- stall_cnt increments each cycle StallF=1. flush_cnt increments each cycle FlushD|FlushE=1. Both wrap modulo 2^CNT_W and do not count while rst=1.
- Reset values: state RUN, wait_cnt 0, halted 0, stall_cnt 0, flush_cnt 0. Reset mid-MEM_WAIT or in HALT returns to RUN the next cycle.
- mem_ready_M with no outstanding wait is ignored.

Decomposition:
- Shared package mips_pkg holds:
  - FWD_NONE/FWD_WB/FWD_MEM encodings.
  - hz_state_t enum {RUN, MEM_WAIT, HALT}.
  - Register-index width constant (5).
- One sub-module, pipe_fwd_unit: purely combinational ForwardAE/BE/AD/BD comparators.
- FSM, stall and flush priority logic, and counters stay in pipe_hazard_ctrl.

Test Plan:
- Forwarding: RsE=RtE=8, WriteRegM=8, RegWriteM=1, WriteRegW=8, RegWriteW=1 -> ForwardAE=ForwardBE=10. Drop RegWriteM -> 01. Set RsE=0 -> ForwardAE=00.
- Load-use: MemtoRegE=1, RtE=9, RsD=9 -> StallF=StallD=FlushE=1 for exactly 1 cycle; stall_cnt +1.
- Branch hazard: BranchD=1, RegWriteE=1, WriteRegE=RtD=4 -> stall 1 cycle. Next cycle, with MemtoRegM=1 and WriteRegM=4, stall again. With PCSrcD=1 and no stall -> FlushD=1, flush_cnt +1.
- Memory wait: mem_req_M=1, mem_ready_M=0 for 3 cycles, then 1 -> StallF/D/E/M=1 and FlushW=1 for 3 cycles, back to RUN; lwstall asserted meanwhile gives FlushE=0.
- Watchdog: MEM_TIMEOUT=4, mem_ready_M held 0 -> halted=1 after 4 MEM_WAIT cycles, all stalls held. Ready in the timeout cycle -> RUN, halted=0.
- Reset: assert rst during MEM_WAIT and during HALT -> next cycle state RUN, halted=0, counters 0; while rst=1, FlushD=FlushE=FlushW=1 and all stalls 0.
